// File: rtl/fx1_pipe_stage.sv
// Fixed-latency register chain carrying FX1 ALU results to register-file writeback,
// with per-stage forwarding taps and pipe-wide stall/flush.
module fx1_pipe_stage #(
    parameter int LATENCY = 2,
    parameter int DATA_W  = 128,
    parameter int RT_W    = 7,
    parameter int ID_W    = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ID_W-1:0]            in_instr_id,
    input  logic [RT_W-1:0]            in_rt_addr,
    input  logic                       in_reg_wr,
    input  logic [0:DATA_W-1]          in_result,
    input  logic                       stall,
    input  logic                       flush,
    output logic [LATENCY-1:0]         fwd_valid,
    output logic [LATENCY*RT_W-1:0]    fwd_rt_addr,
    output logic [LATENCY*DATA_W-1:0]  fwd_data,
    output logic                       wb_valid,
    output logic                       wb_reg_wr,
    output logic [RT_W-1:0]            wb_rt_addr,
    output logic [0:DATA_W-1]          wb_data,
    output logic [ID_W-1:0]            wb_instr_id,
    output logic [31:0]                issue_count
);

    // Index 0 is stage 1 (nearest the ALU); index LATENCY-1 feeds writeback.
    logic [LATENCY-1:0] valid_reg;
    logic [LATENCY-1:0] reg_wr_reg;
    logic [RT_W-1:0]    rt_reg   [LATENCY];
    logic [ID_W-1:0]    id_reg   [LATENCY];
    logic [0:DATA_W-1]  data_reg [LATENCY];
    logic [31:0]        issue_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= '0;
            reg_wr_reg <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                rt_reg[k]   <= '0;
                id_reg[k]   <= '0;
                data_reg[k] <= '0;
            end
        end else if (flush) begin
            // Payload fields are left as-is; only the live flags matter after a kill.
            valid_reg  <= '0;
            reg_wr_reg <= '0;
        end else if (!stall) begin
            for (int k = LATENCY - 1; k > 0; k--) begin
                valid_reg[k]  <= valid_reg[k-1];
                reg_wr_reg[k] <= reg_wr_reg[k-1];
                rt_reg[k]     <= rt_reg[k-1];
                id_reg[k]     <= id_reg[k-1];
                data_reg[k]   <= data_reg[k-1];
            end
            valid_reg[0]  <= in_valid;
            reg_wr_reg[0] <= in_valid & in_reg_wr;
            rt_reg[0]     <= in_rt_addr;
            id_reg[0]     <= in_instr_id;
            data_reg[0]   <= in_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count_reg <= '0;
        end else if (in_valid && !stall && !flush && (issue_count_reg != 32'hFFFF_FFFF)) begin
            issue_count_reg <= issue_count_reg + 32'd1;
        end
    end

    // Forwarding taps expose raw stage contents; the bypass network picks among matches.
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tap
            assign fwd_valid[gi]                   = valid_reg[gi] & reg_wr_reg[gi];
            assign fwd_rt_addr[gi*RT_W +: RT_W]    = rt_reg[gi];
            assign fwd_data[gi*DATA_W +: DATA_W]   = data_reg[gi];
        end
    endgenerate

    assign wb_valid    = valid_reg[LATENCY-1];
    assign wb_reg_wr   = valid_reg[LATENCY-1] & reg_wr_reg[LATENCY-1];
    assign wb_rt_addr  = rt_reg[LATENCY-1];
    assign wb_data     = data_reg[LATENCY-1];
    assign wb_instr_id = id_reg[LATENCY-1];
    assign issue_count = issue_count_reg;

endmodule

// File: tb/tb_fx1_pipe_stage.sv
// Directed plus randomized bench for fx1_pipe_stage, checked against a queue-based
// model of in-flight instructions.
module tb_fx1_pipe_stage;

    localparam int L  = 2;
    localparam int DW = 128;
    localparam int RW = 7;
    localparam int IW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [IW-1:0]   in_instr_id;
    logic [RW-1:0]   in_rt_addr;
    logic            in_reg_wr;
    logic [DW-1:0]   in_result;
    logic            stall;
    logic            flush;
    logic [L-1:0]    fwd_valid;
    logic [L*RW-1:0] fwd_rt_addr;
    logic [L*DW-1:0] fwd_data;
    logic            wb_valid;
    logic            wb_reg_wr;
    logic [RW-1:0]   wb_rt_addr;
    logic [DW-1:0]   wb_data;
    logic [IW-1:0]   wb_instr_id;
    logic [31:0]     issue_count;

    fx1_pipe_stage #(.LATENCY(L), .DATA_W(DW), .RT_W(RW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr_id(in_instr_id),
        .in_rt_addr(in_rt_addr), .in_reg_wr(in_reg_wr), .in_result(in_result),
        .stall(stall), .flush(flush), .fwd_valid(fwd_valid), .fwd_rt_addr(fwd_rt_addr),
        .fwd_data(fwd_data), .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr),
        .wb_rt_addr(wb_rt_addr), .wb_data(wb_data), .wb_instr_id(wb_instr_id),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          w;
        logic [RW-1:0] rt;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } ent_t;

    ent_t        pipe[$];   // pipe[0] = youngest (stage 1), pipe[L-1] = writeback
    logic [31:0] m_count;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_no   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.w = 0; e.rt = '0; e.id = '0; e.d = '0;
        pipe.delete();
        for (int k = 0; k < L; k++) pipe.push_back(e);
        m_count = '0;
    endtask

    // full=1 also compares payload of dead stages (used right after reset).
    task automatic check_all(input bit full);
        logic [L-1:0] exp_fv;
        for (int k = 0; k < L; k++) exp_fv[k] = pipe[k].v & pipe[k].w;
        chk("fwd_valid", fwd_valid, exp_fv);
        chk("issue_count", issue_count, m_count);
        chk("wb_valid", wb_valid, pipe[L-1].v);
        chk("wb_reg_wr", wb_reg_wr, pipe[L-1].v & pipe[L-1].w);
        for (int k = 0; k < L; k++) begin
            if (full || pipe[k].v) begin
                chk($sformatf("fwd_rt_addr[%0d]", k), fwd_rt_addr[k*RW +: RW], pipe[k].rt);
                chk($sformatf("fwd_data[%0d]", k), fwd_data[k*DW +: DW], pipe[k].d);
            end
        end
        if (full || pipe[L-1].v) begin
            chk("wb_rt_addr", wb_rt_addr, pipe[L-1].rt);
            chk("wb_data", wb_data, pipe[L-1].d);
            chk("wb_instr_id", wb_instr_id, pipe[L-1].id);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, check outputs.
    task automatic cyc(input logic v, input logic [IW-1:0] id, input logic [RW-1:0] rt,
                       input logic w, input logic [DW-1:0] res,
                       input logic st, input logic fl, input logic r);
        ent_t e;
        ent_t old;
        in_valid = v; in_instr_id = id; in_rt_addr = rt; in_reg_wr = w; in_result = res;
        stall = st; flush = fl; rst = r;
        @(posedge clk);
        cyc_no++;
        if (r) begin
            model_reset();
        end else if (fl) begin
            for (int k = 0; k < L; k++) begin pipe[k].v = 0; pipe[k].w = 0; end
        end else if (!st) begin
            e.v = v; e.w = v & w; e.rt = rt; e.id = id; e.d = res;
            pipe.push_front(e);
            old = pipe.pop_back();
            if (v && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
        #1;
        check_all(r);
        $display("cycle %0d: v=%0b rt=%0d st=%0b fl=%0b rst=%0b -> wb_valid=%0b wb_rt=%0d cnt=%0d",
                 cyc_no, v, rt, st, fl, r, wb_valid, wb_rt_addr, issue_count);
    endtask

    task automatic issue(input logic [RW-1:0] rt, input logic [DW-1:0] res);
        cyc(1'b1, IW'(rt + 7'd40), rt, 1'b1, res, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, {4{$urandom}}, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [DW-1:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        model_reset();
        in_valid = 0; in_instr_id = '0; in_rt_addr = '0; in_reg_wr = 0;
        in_result = '0; stall = 0; flush = 0; rst = 1;

        // Reset state
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 7'd3, 7'd9, 1'b1, PAT, 1'b1, 1'b1, 1'b1);

        // Basic latency
        cyc(1'b1, 7'd11, 7'd5, 1'b1, PAT, 1'b0, 1'b0, 1'b0);
        chk("basic_fwd_valid_c1", fwd_valid, 2'b01);
        chk("basic_fwd_rt_c1", fwd_rt_addr[0 +: RW], 7'd5);
        idle();
        chk("basic_wb_reg_wr_c2", wb_reg_wr, 1'b1);
        chk("basic_wb_data_c2", wb_data, PAT);
        idle();

        // Back-to-back
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        issue(7'd1, 128'h11); issue(7'd2, 128'h22); issue(7'd3, 128'h33);
        chk("b2b_wb_rt_c3", wb_rt_addr, 7'd2);
        idle();
        chk("b2b_wb_rt_c4", wb_rt_addr, 7'd3);
        chk("b2b_count", issue_count, 32'd3);
        idle();

        // Stall hold with a not-to-be-counted instruction presented during the stall
        issue(7'd9, 128'h99);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 7'd1, 7'd100, 1'b1, 128'hBAD, 1'b1, 1'b0, 1'b0);
            chk("stall_wb_valid", wb_valid, 1'b0);
        end
        idle();
        chk("stall_wb_rt", wb_rt_addr, 7'd9);
        chk("stall_count", issue_count, 32'd4);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall_wb_reg_wr_held", wb_reg_wr, 1'b1);
        idle();

        // Flush beats stall
        issue(7'd20, 128'h20); issue(7'd21, 128'h21);
        cyc(1'b1, 7'd5, 7'd22, 1'b1, 128'h22, 1'b1, 1'b1, 1'b0);
        chk("flush_fwd_valid", fwd_valid, 2'b00);
        chk("flush_wb_reg_wr", wb_reg_wr, 1'b0);
        chk("flush_count", issue_count, 32'd6);
        idle(); idle();

        // Reset mid-operation
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) issue(7'(i + 30), {4{$urandom}});
        chk("rst_pre_count", issue_count, 32'd10);
        cyc(1'b1, 7'd2, 7'd77, 1'b1, PAT, 1'b1, 1'b0, 1'b1);
        chk("rst_count", issue_count, 32'd0);
        issue(7'd44, 128'h44); idle();
        chk("rst_after_wb_rt", wb_rt_addr, 7'd44);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 7'($urandom), 7'($urandom), 1'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 49) == 0));
        end

        // Saturation
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        force dut.issue_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.issue_count_reg;
        m_count = 32'hFFFF_FFFE;
        issue(7'd1, 128'h1); issue(7'd2, 128'h2); issue(7'd3, 128'h3);
        chk("sat_count", issue_count, 32'hFFFF_FFFF);
        idle();
        chk("sat_hold", issue_count, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
